// File: rtl/serial_shifter_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM states
// and the default datapath width.
`timescale 1ns/1ps
package serial_shifter_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SLL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_shifter.sv
// Iterative shifter: one bit of shift per clock, result held in the shift
// register and flagged by a single-cycle valid pulse.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | ready=1, waiting for start; operands captured on accept
//  ST_SHIFT | one single-bit shift per cycle until the down-counter is 0
//  ST_DONE  | valid=1 for this cycle only, then back to ST_IDLE
//
// The op port is named optype because "type" is a reserved word.
`timescale 1ns/1ps
module serial_shifter
  import serial_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       optype,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] r
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] step;
  logic [SHW-1:0]   count;
  logic             valid_q;

  // Single-bit shift of the register according to the captured op
  always_comb begin
    step = sreg;
    case (op_q)
      OP_SRL:  step = {1'b0, sreg[WIDTH-1:1]};
      OP_SLL:  step = {sreg[WIDTH-2:0], 1'b0};
      OP_SRA:  step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      default: step = sreg;
    endcase
  end

  // Sequencer: capture on accept, shift while count!=0, pulse valid in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_SRL;
      sreg    <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            sreg  <= a;
            op_q  <= op_e'(optype);
            count <= (op_e'(optype) == OP_PASS) ? '0 : shamt;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (count != '0) begin
            sreg  <= step;
            count <= count - CNT_ONE;
          end else begin
            state   <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = (state == ST_IDLE);
  assign valid = valid_q;
  assign r     = sreg;

endmodule
